riscv_frontend: RTL and testbench

Instruction front end of the out-of-order RV32I core: fetches instructions byte-serially from unified RAM, buffers them with their PCs in a circular instruction queue, and decodes the queue head combinationally for the register-file/ROB dispatch stage. It comprises fetcher (fc), instruction queue (iq) and decoder (dc). On a ROB redirect it flushes and refetches from the new PC.

---
 rtl/riscv_frontend_pkg.sv | 60 ++++++
 rtl/rv32i_decoder.sv | 143 ++++++++++++++
 rtl/riscv_frontend.sv | 139 +++++++++++++
 tb/tb_riscv_frontend.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_frontend_pkg.sv
// Shared types for the RV32I front end: op codes, instruction formats,
// fetcher states and the instruction-queue entry.
package riscv_frontend_pkg;

    localparam int XLEN = 32;
    localparam int OP_W = 6;

    typedef enum logic [OP_W-1:0] {
        OP_INVALID = 6'd0, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_e;

    typedef enum logic [2:0] {
        FMT_X, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    typedef enum logic [2:0] {
        FS_IDLE, FS_A0, FS_A1, FS_A2, FS_A3, FS_C
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } iq_entry_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Which field layout an op uses; drives operand/immediate extraction.
    function automatic fmt_e op_fmt(input op_e op);
        case (op)
            OP_LUI, OP_AUIPC:                               op_fmt = FMT_U;
            OP_JAL:                                         op_fmt = FMT_J;
            OP_JALR, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
            OP_ANDI:                                        op_fmt = FMT_I;
            OP_SLLI, OP_SRLI, OP_SRAI:                      op_fmt = FMT_SH;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU,
            OP_BGEU:                                        op_fmt = FMT_B;
            OP_SB, OP_SH, OP_SW:                            op_fmt = FMT_S;
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
            OP_SRL, OP_SRA, OP_OR, OP_AND:                  op_fmt = FMT_R;
            default:                                        op_fmt = FMT_X;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decoder for the instruction-queue head; all outputs
// read zero (and is_empty=1) when no valid entry is presented.
module rv32i_decoder
    import riscv_frontend_pkg::*;
(
    input  logic        valid,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        is_empty,
    output logic [31:0] pc_out,
    output logic [5:0]  op,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    op_e        op_d;
    fmt_e       fmt;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    always_comb begin
        op_d = OP_INVALID;
        if (valid) begin
            case (opc)
                OPC_LUI:   op_d = OP_LUI;
                OPC_AUIPC: op_d = OP_AUIPC;
                OPC_JAL:   op_d = OP_JAL;
                OPC_JALR:  if (f3 == 3'b000) op_d = OP_JALR;
                OPC_BRANCH: case (f3)
                    3'b000:  op_d = OP_BEQ;
                    3'b001:  op_d = OP_BNE;
                    3'b100:  op_d = OP_BLT;
                    3'b101:  op_d = OP_BGE;
                    3'b110:  op_d = OP_BLTU;
                    3'b111:  op_d = OP_BGEU;
                    default: op_d = OP_INVALID;
                endcase
                OPC_LOAD: case (f3)
                    3'b000:  op_d = OP_LB;
                    3'b001:  op_d = OP_LH;
                    3'b010:  op_d = OP_LW;
                    3'b100:  op_d = OP_LBU;
                    3'b101:  op_d = OP_LHU;
                    default: op_d = OP_INVALID;
                endcase
                OPC_STORE: case (f3)
                    3'b000:  op_d = OP_SB;
                    3'b001:  op_d = OP_SH;
                    3'b010:  op_d = OP_SW;
                    default: op_d = OP_INVALID;
                endcase
                OPC_OPIMM: case (f3)
                    3'b000:  op_d = OP_ADDI;
                    3'b010:  op_d = OP_SLTI;
                    3'b011:  op_d = OP_SLTIU;
                    3'b100:  op_d = OP_XORI;
                    3'b110:  op_d = OP_ORI;
                    3'b111:  op_d = OP_ANDI;
                    3'b001:  if (f7 == F7_BASE) op_d = OP_SLLI;
                    default: begin
                        if (f7 == F7_BASE)     op_d = OP_SRLI;
                        else if (f7 == F7_ALT) op_d = OP_SRAI;
                    end
                endcase
                OPC_OP: begin
                    if (f7 == F7_BASE) begin
                        case (f3)
                            3'b000:  op_d = OP_ADD;
                            3'b001:  op_d = OP_SLL;
                            3'b010:  op_d = OP_SLT;
                            3'b011:  op_d = OP_SLTU;
                            3'b100:  op_d = OP_XOR;
                            3'b101:  op_d = OP_SRL;
                            3'b110:  op_d = OP_OR;
                            default: op_d = OP_AND;
                        endcase
                    end else if (f7 == F7_ALT) begin
                        if (f3 == 3'b000)      op_d = OP_SUB;
                        else if (f3 == 3'b101) op_d = OP_SRA;
                    end
                end
                default: op_d = OP_INVALID;
            endcase
        end
    end

    // Invalid/empty decode to FMT_X, so every field stays zero.
    always_comb begin
        fmt = op_fmt(op_d);
        rd  = '0;
        rs1 = '0;
        rs2 = '0;
        imm = '0;
        case (fmt)
            FMT_R: begin
                rd  = instr[11:7];
                rs1 = instr[19:15];
                rs2 = instr[24:20];
            end
            FMT_I: begin
                rd  = instr[11:7];
                rs1 = instr[19:15];
                imm = {{20{instr[31]}}, instr[31:20]};
            end
            FMT_SH: begin
                rd  = instr[11:7];
                rs1 = instr[19:15];
                imm = {27'd0, instr[24:20]};
            end
            FMT_S: begin
                rs1 = instr[19:15];
                rs2 = instr[24:20];
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            FMT_B: begin
                rs1 = instr[19:15];
                rs2 = instr[24:20];
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            FMT_U: begin
                rd  = instr[11:7];
                imm = {instr[31:12], 12'd0};
            end
            FMT_J: begin
                rd  = instr[11:7];
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    assign is_empty = ~valid;
    assign pc_out   = valid ? pc : '0;
    assign op       = op_d;

endmodule

// File: rtl/riscv_frontend.sv
// RV32I front end: byte-serial fetcher, circular instruction queue and a
// combinational decode of the queue head for dispatch.
module riscv_frontend
    import riscv_frontend_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic [7:0]  mem_dout,
    input  logic        is_stall_from_rob,
    input  logic        is_exception_from_rob,
    input  logic [31:0] pc_from_rob,
    output logic        is_empty_to_reg,
    output logic [31:0] pc_to_reg,
    output logic [5:0]  op_to_reg,
    output logic [4:0]  rd_to_reg,
    output logic [4:0]  rs1_to_reg,
    output logic [4:0]  rs2_to_reg,
    output logic [31:0] imm_to_reg
);

    localparam int            PW   = $clog2(DEPTH);
    localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

    fetch_state_e  state;
    logic [31:0]   pc;
    logic [23:0]   asm_buf;

    iq_entry_t     iq [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;
    logic          head_vld;
    iq_entry_t     head_e;

    logic flush, push, pop;

    assign mem_wr   = 1'b0;
    assign mem_dout = 8'h00;

    assign head_vld = (count != '0);
    assign head_e   = iq[head];

    // While frozen nothing moves, and redirects wait for rdy.
    always_comb begin
        flush = rdy & is_exception_from_rob;
        push  = rdy & ~flush & (state == FS_C);
        pop   = rdy & ~flush & head_vld & ~is_stall_from_rob;
    end

    // Byte k of the word is on mem_din one state after its address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FS_IDLE;
            pc      <= '0;
            mem_a   <= '0;
            asm_buf <= '0;
        end else if (!rdy) begin
            state <= FS_IDLE;
        end else if (is_exception_from_rob) begin
            state <= FS_IDLE;
            pc    <= pc_from_rob;
        end else begin
            case (state)
                FS_IDLE: if (count < FULL) begin
                    state <= FS_A0;
                    mem_a <= pc;
                end
                FS_A0: begin
                    state <= FS_A1;
                    mem_a <= pc + 32'd1;
                end
                FS_A1: begin
                    state         <= FS_A2;
                    mem_a         <= pc + 32'd2;
                    asm_buf[7:0]  <= mem_din;
                end
                FS_A2: begin
                    state         <= FS_A3;
                    mem_a         <= pc + 32'd3;
                    asm_buf[15:8] <= mem_din;
                end
                FS_A3: begin
                    state          <= FS_C;
                    asm_buf[23:16] <= mem_din;
                end
                FS_C: begin
                    state <= FS_IDLE;
                    pc    <= pc + 32'd4;
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A fetch only starts below FULL and count cannot grow mid-fetch,
    // so a push never lands on a full queue.
    always_ff @(posedge clk) begin
        if (push) iq[tail] <= '{pc: pc, instr: {mem_din, asm_buf}};
    end

    rv32i_decoder u_dec (
        .valid    (head_vld),
        .instr    (head_e.instr),
        .pc       (head_e.pc),
        .is_empty (is_empty_to_reg),
        .pc_out   (pc_to_reg),
        .op       (op_to_reg),
        .rd       (rd_to_reg),
        .rs1      (rs1_to_reg),
        .rs2      (rs2_to_reg),
        .imm      (imm_to_reg)
    );

endmodule

// File: tb/tb_riscv_frontend.sv
// Directed bench for riscv_frontend: byte RAM model, fixed cycle timeline,
// hand-computed decode results.
module tb_riscv_frontend;
    import riscv_frontend_pkg::*;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic        is_stall_from_rob;
    logic        is_exception_from_rob;
    logic [31:0] pc_from_rob;
    logic        is_empty_to_reg;
    logic [31:0] pc_to_reg;
    logic [5:0]  op_to_reg;
    logic [4:0]  rd_to_reg, rs1_to_reg, rs2_to_reg;
    logic [31:0] imm_to_reg;

    logic [7:0]  mem [4096];
    int          n_cmp = 0;
    int          n_mis = 0;
    op_e         exp_op [16];

    riscv_frontend #(.DEPTH(16)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .mem_din               (mem_din),
        .mem_a                 (mem_a),
        .mem_wr                (mem_wr),
        .mem_dout              (mem_dout),
        .is_stall_from_rob     (is_stall_from_rob),
        .is_exception_from_rob (is_exception_from_rob),
        .pc_from_rob           (pc_from_rob),
        .is_empty_to_reg       (is_empty_to_reg),
        .pc_to_reg             (pc_to_reg),
        .op_to_reg             (op_to_reg),
        .rd_to_reg             (rd_to_reg),
        .rs1_to_reg            (rs1_to_reg),
        .rs2_to_reg            (rs2_to_reg),
        .imm_to_reg            (imm_to_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: read data valid one cycle after the address.
    always @(posedge clk) mem_din <= mem[mem_a[11:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_dec(input string tag, input logic [31:0] pc, input op_e op,
                           input int rd, input int rs1, input int rs2, input logic [31:0] imm);
        chk({tag, ".empty"}, 32'(is_empty_to_reg), 32'd0);
        chk({tag, ".pc"},    pc_to_reg, pc);
        chk({tag, ".op"},    32'(op_to_reg), 32'(op));
        chk({tag, ".rd"},    32'(rd_to_reg), rd);
        chk({tag, ".rs1"},   32'(rs1_to_reg), rs1);
        chk({tag, ".rs2"},   32'(rs2_to_reg), rs2);
        chk({tag, ".imm"},   imm_to_reg, imm);
    endtask

    task automatic put(input int a, input logic [31:0] w);
        mem[a]   = w[7:0];
        mem[a+1] = w[15:8];
        mem[a+2] = w[23:16];
        mem[a+3] = w[31:24];
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_one();
        is_stall_from_rob = 1'b0;
        @(negedge clk);
        is_stall_from_rob = 1'b1;
    endtask

    initial begin
        for (int a = 0; a < 4096; a += 4) put(a, 32'h0000_0013);
        put(0,      32'h0050_0513);   // addi x10,x0,5
        put(4,      32'hFFFF_F0B7);   // lui  x1,0xFFFFF
        put(8,      32'hFE20_8EE3);   // beq  x1,x2,-4
        put(12,     32'hFFFF_FFFF);   // invalid
        put(32'h100, 32'h0050_0513);  // addi x10,x0,5
        put(32'h104, 32'h4033_5293);  // srai x5,x6,3
        put(32'h108, 32'hFE51_2C23);  // sw   x5,-8(x2)
        foreach (exp_op[k]) exp_op[k] = OP_ADDI;
        exp_op[1] = OP_LUI;
        exp_op[2] = OP_BEQ;
        exp_op[3] = OP_INVALID;

        rst = 1'b0; rdy = 1'b1; is_stall_from_rob = 1'b1;
        is_exception_from_rob = 1'b0; pc_from_rob = '0;
        step(2);
        chk("rst.empty", 32'(is_empty_to_reg), 32'd1);
        chk("rst.mem_a", mem_a, 32'd0);
        chk("rst.mem_wr", 32'(mem_wr), 32'd0);
        chk("rst.mem_dout", 32'(mem_dout), 32'd0);
        chk("rst.pc", pc_to_reg, 32'd0);
        chk("rst.op", 32'(op_to_reg), 32'd0);
        chk("rst.imm", imm_to_reg, 32'd0);
        rst = 1'b1;

        step(1);                              // cycle 1
        chk("c1.mem_a", mem_a, 32'd0);
        chk("c1.empty", 32'(is_empty_to_reg), 32'd1);
        step(4);                              // cycle 5
        chk("c5.empty", 32'(is_empty_to_reg), 32'd1);
        step(1);                              // cycle 6
        chk_dec("addi", 32'd0, OP_ADDI, 10, 0, 0, 32'd5);

        // Stalled: the queue fills to 16 and the fetcher parks.
        step(100);
        chk("full.mem_a", mem_a, 32'h3F);
        chk("full.head", pc_to_reg, 32'd0);
        step(20);
        chk("full.mem_a_hold", mem_a, 32'h3F);

        for (int k = 0; k < 16; k++) begin
            chk("drain.empty", 32'(is_empty_to_reg), 32'd0);
            chk("drain.pc", pc_to_reg, 32'(4 * k));
            chk("drain.op", 32'(op_to_reg), 32'(exp_op[k]));
            if (k == 1) chk_dec("lui", 32'd4, OP_LUI, 1, 0, 0, 32'hFFFF_F000);
            if (k == 2) chk_dec("beq", 32'd8, OP_BEQ, 0, 1, 2, 32'hFFFF_FFFC);
            pop_one();
            if (k == 0) begin
                step(1);
                chk("refetch.mem_a", mem_a, 32'd64);
            end
        end
        chk("resume.empty", 32'(is_empty_to_reg), 32'd0);
        chk("resume.pc", pc_to_reg, 32'd64);

        // Refill from 0x200 to exactly 3 entries, mid-fetch of the 4th.
        is_exception_from_rob = 1'b1; pc_from_rob = 32'h200;
        step(1);
        is_exception_from_rob = 1'b0;
        chk("redir0.empty", 32'(is_empty_to_reg), 32'd1);
        step(6);
        chk("redir0.pc", pc_to_reg, 32'h200);
        step(15);
        chk("redir0.a2", mem_a, 32'h20E);
        chk("redir0.head", pc_to_reg, 32'h200);

        is_exception_from_rob = 1'b1; pc_from_rob = 32'h100;
        step(1);
        is_exception_from_rob = 1'b0;
        chk("redir.empty", 32'(is_empty_to_reg), 32'd1);
        step(1);
        chk("redir.mem_a", mem_a, 32'h100);
        step(4);
        chk("redir.empty5", 32'(is_empty_to_reg), 32'd1);
        step(1);
        chk_dec("redir", 32'h100, OP_ADDI, 10, 0, 0, 32'd5);

        // Freeze during A2 of the 0x104 fetch; pops and a redirect are held off.
        step(3);
        chk("frz.a2", mem_a, 32'h106);
        rdy = 1'b0; is_stall_from_rob = 1'b0;
        step(1);
        chk("frz.pc1", pc_to_reg, 32'h100);
        chk("frz.empty1", 32'(is_empty_to_reg), 32'd0);
        is_exception_from_rob = 1'b1; pc_from_rob = 32'h300;
        step(1);
        is_exception_from_rob = 1'b0;
        chk("frz.pc2", pc_to_reg, 32'h100);
        step(1);
        chk("frz.pc3", pc_to_reg, 32'h100);
        rdy = 1'b1; is_stall_from_rob = 1'b1;
        step(1);
        chk("frz.restart", mem_a, 32'h104);
        step(5);
        chk("frz.head", pc_to_reg, 32'h100);
        pop_one();
        chk_dec("srai", 32'h104, OP_SRAI, 5, 6, 0, 32'd3);
        pop_one();
        chk("frz.nodup", 32'(is_empty_to_reg), 32'd1);
        step(4);
        chk_dec("sw", 32'h108, OP_SW, 0, 2, 5, 32'hFFFF_FFF8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
